genx_qspi_decoder: RTL and testbench

- Oversampling QSPI target front end, directly upstream of genx_qspi_handler.
- Samples the raw SCK, CSn and IO[3:0] pins in the system clock domain, counts SCK rising edges, and deserialises the opcode and 32-bit address.
- Raises notify_read once the command phase is complete and notify_write once chip-select releases.
- Its outputs drive the handler's sck_counts, opcode, address, chip_select, async_notify_read and async_notify_write inputs.

---
 rtl/genx_qspi_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_genx_qspi_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genx_qspi_decoder.sv
// ============================================================================
// genx_qspi_decoder - oversampling QSPI target front end: SCK edge count,
// opcode/address deserialiser. Define QSPI_DUMMY_EN to add a dummy-edge phase.
// Rev 1.0
// ============================================================================
`default_nettype none

module genx_qspi_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        qspi_sck,
  input  logic [1:0]  qspi_csn,
  input  logic [3:0]  qspi_io,
  output logic [9:0]  sck_counts,
  output logic [7:0]  opcode,
  output logic [31:0] address,
  output logic [1:0]  chip_select,
  output logic        notify_read,
  output logic        notify_write,
  output logic        aborted
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_OPCODE   = 3'd1;
  localparam logic [2:0] c_ADDR     = 3'd2;
  localparam logic [2:0] c_DUMMY    = 3'd3;
  localparam logic [2:0] c_CMD_DONE = 3'd4;

  // Dummy phase length; forced to zero when the dummy phase is compiled out.
`ifdef QSPI_DUMMY_EN
  localparam int c_DUMMY_EDGES = DUMMY_CYCLES;
`else
  localparam int c_DUMMY_EDGES = DUMMY_CYCLES * 0;
`endif
  localparam logic [2:0] c_AFTER_ADDR = (c_DUMMY_EDGES > 0) ? c_DUMMY : c_CMD_DONE;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [1:0]             r_csn_sync [SYNC_STAGES];
  logic [3:0]             r_io_sync  [SYNC_STAGES];
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  logic                   w_sck;
  logic [1:0]             w_csn;
  logic [3:0]             w_io;
  logic                   w_sck_rise;
  logic                   w_cs_any;
  logic                   w_cs_start;

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;

  logic [9:0]             r_sck_counts;
  logic [7:0]             r_opcode;
  logic [31:0]            r_address;
  logic [1:0]             r_chip_select;
  logic                   r_notify_write;
  logic                   r_aborted;
  logic [27:0]            r_shift;
  logic [2:0]             r_bit_cnt;

  logic                   w_start;
  logic                   w_count;
  logic                   w_shift_op;
  logic                   w_shift_nib;
  logic                   w_load_op;
  logic                   w_load_addr;
  logic                   w_abort;
  logic                   w_done_release;
  logic                   w_dummy_inc;
  logic                   w_dummy_last;

  // ---------------------------------------------------------------------------
  // Pin synchronisers; IO shares SCK's stage so data and edge stay aligned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_csn_sync[i] <= 2'b11;
        r_io_sync[i]  <= 4'h0;
      end
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], qspi_sck};
      r_csn_sync[0] <= qspi_csn;
      r_io_sync[0]  <= qspi_io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_csn_sync[i] <= r_csn_sync[i-1];
        r_io_sync[i]  <= r_io_sync[i-1];
      end
      r_sck_prev <= w_sck;
      r_cs_prev  <= w_cs_any;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_csn      = r_csn_sync[SYNC_STAGES-1];
  assign w_io       = r_io_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_cs_any   = ~(&w_csn);
  assign w_cs_start = w_cs_any & ~r_cs_prev;

  // ---------------------------------------------------------------------------
  // Dummy-edge counter
  // ---------------------------------------------------------------------------
`ifdef QSPI_DUMMY_EN
  localparam int c_DCW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  logic [c_DCW-1:0] r_dummy_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dummy_cnt <= '0;
    end else if (w_start) begin
      r_dummy_cnt <= '0;
    end else if (w_dummy_inc) begin
      r_dummy_cnt <= r_dummy_cnt + c_DCW'(1);
    end
  end

  assign w_dummy_last = (r_dummy_cnt == c_DCW'(DUMMY_CYCLES - 1));
`else
  assign w_dummy_last = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. CS release outranks a coincident SCK edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_cs_start) w_state_nxt = c_OPCODE;
      end
      c_OPCODE: begin
        if (!w_cs_any)                             w_state_nxt = c_IDLE;
        else if (w_sck_rise && r_bit_cnt == 3'd7)  w_state_nxt = c_ADDR;
      end
      c_ADDR: begin
        if (!w_cs_any)                             w_state_nxt = c_IDLE;
        else if (w_sck_rise && r_bit_cnt == 3'd7)  w_state_nxt = c_AFTER_ADDR;
      end
`ifdef QSPI_DUMMY_EN
      c_DUMMY: begin
        if (!w_cs_any)                             w_state_nxt = c_IDLE;
        else if (w_sck_rise && w_dummy_last)       w_state_nxt = c_CMD_DONE;
      end
`endif
      c_CMD_DONE: begin
        if (!w_cs_any) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    w_start        = 1'b0;
    w_count        = 1'b0;
    w_shift_op     = 1'b0;
    w_shift_nib    = 1'b0;
    w_load_op      = 1'b0;
    w_load_addr    = 1'b0;
    w_abort        = 1'b0;
    w_done_release = 1'b0;
    w_dummy_inc    = 1'b0;
    notify_read    = (r_state == c_CMD_DONE);
    case (r_state)
      c_IDLE: begin
        w_start = w_cs_start;
      end
      c_OPCODE: begin
        w_count    = w_sck_rise;
        w_shift_op = w_sck_rise & w_cs_any;
        w_load_op  = w_sck_rise & w_cs_any & (r_bit_cnt == 3'd7);
        w_abort    = ~w_cs_any;
      end
      c_ADDR: begin
        w_count     = w_sck_rise;
        w_shift_nib = w_sck_rise & w_cs_any;
        w_load_addr = w_sck_rise & w_cs_any & (r_bit_cnt == 3'd7);
        w_abort     = ~w_cs_any;
      end
      c_DUMMY: begin
        w_count     = w_sck_rise;
        w_dummy_inc = w_sck_rise & w_cs_any;
        w_abort     = ~w_cs_any;
      end
      c_CMD_DONE: begin
        w_count        = w_sck_rise;
        w_done_release = ~w_cs_any;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_counts   <= '0;
      r_opcode       <= '0;
      r_address      <= '0;
      r_chip_select  <= '0;
      r_notify_write <= 1'b0;
      r_aborted      <= 1'b0;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
    end else begin
      r_aborted <= w_abort;
      if (w_start) begin
        r_chip_select  <= ~w_csn;
        r_sck_counts   <= '0;
        r_shift        <= '0;
        r_bit_cnt      <= '0;
        r_notify_write <= 1'b0;
      end else begin
        if (w_count && r_sck_counts != 10'h3FF) r_sck_counts <= r_sck_counts + 10'd1;
        if (w_shift_op)  r_shift <= {r_shift[26:0], w_io[0]};
        if (w_shift_nib) r_shift <= {r_shift[23:0], w_io};
        // 3-bit edge counter wraps from opcode straight into the address phase
        if (w_shift_op || w_shift_nib) r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_load_op)   r_opcode  <= {r_shift[6:0], w_io[0]};
        if (w_load_addr) r_address <= {r_shift, w_io};
        if (w_done_release) r_notify_write <= 1'b1;
      end
    end
  end

  assign sck_counts   = r_sck_counts;
  assign opcode       = r_opcode;
  assign address      = r_address;
  assign chip_select  = r_chip_select;
  assign notify_write = r_notify_write;
  assign aborted      = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_genx_qspi_decoder.sv
// ============================================================================
// tb_genx_qspi_decoder - randomized QSPI transactions against a command-level
// model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_genx_qspi_decoder;

  localparam int SYNC  = 2;
  localparam int DUMMY = 8;
`ifdef QSPI_DUMMY_EN
  localparam int CMD_EDGES = 16 + DUMMY;
`else
  localparam int CMD_EDGES = 16;
`endif
  localparam int HALF = SYNC + 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        qspi_sck = 1'b0;
  logic [1:0]  qspi_csn = 2'b11;
  logic [3:0]  qspi_io = 4'h0;
  logic [9:0]  sck_counts;
  logic [7:0]  opcode;
  logic [31:0] address;
  logic [1:0]  chip_select;
  logic        notify_read;
  logic        notify_write;
  logic        aborted;

  int checks = 0;
  int passed = 0;
  int abort_seen = 0;

  // Command-level model: last opcode/address that completed capture
  logic [7:0]  m_op = 8'h00;
  logic [31:0] m_ad = 32'h0;

  genx_qspi_decoder #(
    .SYNC_STAGES  (SYNC),
    .DUMMY_CYCLES (DUMMY)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .qspi_sck     (qspi_sck),
    .qspi_csn     (qspi_csn),
    .qspi_io      (qspi_io),
    .sck_counts   (sck_counts),
    .opcode       (opcode),
    .address      (address),
    .chip_select  (chip_select),
    .notify_read  (notify_read),
    .notify_write (notify_write),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (aborted === 1'b1) abort_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] edge_io(input int k, input logic [7:0] op, input logic [31:0] ad);
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (k < 8)       v[0] = op[7 - k];
    else if (k < 16) v = ad[31 - 4*(k-8) -: 4];
    return v;
  endfunction

  // One full transaction; expectations come from the command-level rules.
  task automatic run_txn(input logic [1:0] sel, input logic [7:0] op, input logic [31:0] ad,
                         input int n, input bit cs_held, input bit other_cs, input bit collide);
    int  exp_cnt;
    bit  complete;
    abort_seen = 0;
    if (!cs_held) qspi_csn = ~sel;
    wait_clks(HALF);
    checks++;
    if (sck_counts !== 10'd0) $display("FAIL start_clear: sck_counts=%0d want 0", sck_counts);
    else passed++;
    for (int k = 0; k < n; k++) begin
      qspi_io = edge_io(k, op, ad);
      wait_clks(HALF);
      qspi_sck = 1'b1;
      if (collide && k == n - 1) qspi_csn = 2'b11;
      if (!collide && k == CMD_EDGES - 1) begin
        repeat (SYNC) @(negedge clk);
        checks++;
        if (notify_read !== 1'b0) $display("FAIL nr_early: notify_read=%b want 0", notify_read);
        else passed++;
        @(negedge clk);
        checks++;
        if (notify_read !== 1'b1) $display("FAIL nr_latency: notify_read=%b want 1", notify_read);
        else passed++;
        wait_clks(HALF - SYNC - 1);
      end else begin
        wait_clks(HALF);
      end
      qspi_sck = 1'b0;
      if (other_cs && k == 2) qspi_csn = 2'b00;
    end
    wait_clks(HALF);
    if (!collide) begin
      checks++;
      if (notify_read !== (n >= CMD_EDGES))
        $display("FAIL nr_hold: notify_read=%b want %b (edges=%0d)", notify_read, (n >= CMD_EDGES), n);
      else passed++;
      qspi_csn = 2'b11;
      wait_clks(HALF);
    end

    complete = (n >= CMD_EDGES) && !(collide && n == CMD_EDGES);
    if (n >= 8)  m_op = op;
    if (n >= 16) m_ad = ad;
    exp_cnt = (n > 1023) ? 1023 : n;

    checks++;
    if (sck_counts !== 10'(exp_cnt)) $display("FAIL sck_counts: got %0d want %0d", sck_counts, exp_cnt);
    else passed++;
    checks++;
    if (opcode !== m_op) $display("FAIL opcode: got %h want %h", opcode, m_op);
    else passed++;
    checks++;
    if (address !== m_ad) $display("FAIL address: got %h want %h", address, m_ad);
    else passed++;
    checks++;
    if (chip_select !== sel) $display("FAIL chip_select: got %b want %b", chip_select, sel);
    else passed++;
    checks++;
    if (notify_read !== 1'b0) $display("FAIL nr_release: notify_read=%b want 0", notify_read);
    else passed++;
    checks++;
    if (notify_write !== complete) $display("FAIL notify_write: got %b want %b", notify_write, complete);
    else passed++;
    checks++;
    if (abort_seen !== (complete ? 0 : 1)) $display("FAIL aborted: pulse cycles=%0d want %0d", abort_seen, complete ? 0 : 1);
    else passed++;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    wait_clks(3);
    checks++;
    if ({sck_counts, opcode, address, chip_select} !== 52'h0)
      $display("FAIL reset_data: cnt=%0d op=%h ad=%h cs=%b want 0", sck_counts, opcode, address, chip_select);
    else passed++;
    checks++;
    if ({notify_read, notify_write, aborted} !== 3'b000)
      $display("FAIL reset_flags: nr/nw/ab=%b want 000", {notify_read, notify_write, aborted});
    else passed++;
    resetn = 1'b1;
    wait_clks(3);
  endtask

  task automatic test_basic;
    run_txn(2'b01, 8'hEB, 32'h1234_5678, CMD_EDGES, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef QSPI_DUMMY_EN
  task automatic test_dummy;
    run_txn(2'b01, 8'($urandom), $urandom, CMD_EDGES + 32, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_abort;
    run_txn(2'b10, 8'($urandom), $urandom, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0] sel;
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0:       sel = 2'b01;
        1:       sel = 2'b10;
        default: sel = 2'b11;
      endcase
      run_txn(sel, 8'($urandom), $urandom, int'($urandom_range(0, CMD_EDGES + 24)), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_saturation;
    run_txn(2'b11, 8'($urandom), $urandom, 1100, 1'b0, 1'b0, 1'b0);
    run_txn(2'b01, 8'($urandom), $urandom, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collision;
    run_txn(2'b01, 8'($urandom), $urandom, 20, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_addr;
    logic [7:0]  op;
    logic [31:0] ad;
    op = 8'($urandom);
    ad = $urandom;
    qspi_csn = 2'b10;
    wait_clks(HALF);
    for (int k = 0; k < 12; k++) begin
      qspi_io = edge_io(k, op, ad);
      wait_clks(HALF);
      qspi_sck = 1'b1;
      wait_clks(HALF);
      qspi_sck = 1'b0;
    end
    wait_clks(2);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({sck_counts, opcode, address, chip_select} !== 52'h0)
      $display("FAIL midreset_data: cnt=%0d op=%h ad=%h cs=%b want 0", sck_counts, opcode, address, chip_select);
    else passed++;
    checks++;
    if ({notify_read, notify_write, aborted} !== 3'b000)
      $display("FAIL midreset_flags: nr/nw/ab=%b want 000", {notify_read, notify_write, aborted});
    else passed++;
    m_op = 8'h00;
    m_ad = 32'h0;
    wait_clks(2);
    resetn = 1'b1;
    run_txn(2'b01, 8'h02, 32'hA5A5_A5A5, CMD_EDGES, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef QSPI_DUMMY_EN
    test_dummy();
`endif
    test_abort();
    test_random();
    test_saturation();
    test_collision();
    test_reset_mid_addr();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
